// File: rtl/csi2_rx_pkg.sv
// Shared constants and types for the CSI-2 receive packet controller.
// Byte positions follow the CSI-2 packet header layout.
package csi2_rx_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle    = 2'd0;
    localparam state_t StHeader  = 2'd1;
    localparam state_t StPayload = 2'd2;
    localparam state_t StFlush   = 2'd3;

    typedef enum logic [1:0] {
        KindPayload,
        KindCrc0,
        KindCrc1,
        KindPad
    } byte_kind_e;

    localparam int unsigned HEADER_BYTES          = 4;
    localparam int unsigned CRC_BYTES             = 2;
    localparam logic [5:0]  SHORT_PACKET_DT_LIMIT = 6'h10;

    localparam int unsigned HDR_DATA_ID = 0;
    localparam int unsigned HDR_WC_LO   = 1;
    localparam int unsigned HDR_WC_HI   = 2;
    localparam int unsigned HDR_ECC     = 3;

endpackage

// File: rtl/csi2_rx_packet_controller_if.sv
// Lane-receiver and protocol-layer signals of the CSI-2 packet controller.
// master is the controller side, slave is the receivers plus protocol layer.
interface csi2_rx_packet_controller_if #(
    parameter int unsigned LANES = 2
);
    logic [LANES-1:0][7:0] lane_data;
    logic [LANES-1:0]      lane_enable;
    logic                  lane_reset;
    logic                  header_valid;
    logic [7:0]            data_id;
    logic [15:0]           word_count;
    logic [7:0]            ecc;
    logic [LANES-1:0][7:0] payload_data;
    logic [LANES-1:0]      payload_valid;
    logic [15:0]           crc;
    logic                  packet_end;
    logic                  error;

    modport master (
        input  lane_data, lane_enable,
        output lane_reset, header_valid, data_id, word_count, ecc,
        output payload_data, payload_valid, crc, packet_end, error
    );

    modport slave (
        output lane_data, lane_enable,
        input  lane_reset, header_valid, data_id, word_count, ecc,
        input  payload_data, payload_valid, crc, packet_end, error
    );
endinterface

// File: rtl/csi2_lane_byte_classifier.sv
// Classifies one lane's byte in a payload-area beat as payload, CRC low/high or padding.
module csi2_lane_byte_classifier
    import csi2_rx_pkg::*;
(
    input  logic [16:0] consumed_i,
    input  logic [15:0] word_count_i,
    input  logic [2:0]  lane_i,
    output byte_kind_e  kind_o
);

    logic [16:0] pos;
    logic [16:0] wc;

    always_comb begin
        pos = consumed_i + {14'd0, lane_i};
        wc  = {1'b0, word_count_i};
        if (pos < wc) begin
            kind_o = KindPayload;
        end else if (pos == wc) begin
            kind_o = KindCrc0;
        end else if (pos == wc + 17'd1) begin
            kind_o = KindCrc1;
        end else begin
            kind_o = KindPad;
        end
    end

endmodule

// File: rtl/csi2_rx_packet_controller.sv
// Merges lane byte strobes into beats, parses the CSI-2 header, forwards payload and CRC,
// and flushes the lane receivers after every packet or abort.
module csi2_rx_packet_controller
    import csi2_rx_pkg::*;
#(
    parameter int unsigned LANES         = 2,
    parameter int unsigned TIMEOUT_WIDTH = 6,
    parameter int unsigned FLUSH_CYCLES  = 4
) (
    input logic                         clock,
    input logic                         reset_n,
    csi2_rx_packet_controller_if.master rx
);

    localparam int unsigned             FlushW   = $clog2(FLUSH_CYCLES + 1);
    localparam logic [16:0]             LanesW   = 17'(LANES);
    localparam logic [2:0]              LanesHdr = 3'(LANES);
    localparam logic [TIMEOUT_WIDTH-1:0] TmoMax  = '1;

    state_t                         state_q, state_d;
    logic [FlushW-1:0]              flush_q, flush_d;
    logic [TIMEOUT_WIDTH-1:0]       tmo_q, tmo_d, tmo_next;
    logic [HEADER_BYTES-1:0][7:0]   hdr_q, hdr_d;
    logic [2:0]                     hdr_cnt_q, hdr_cnt_d, hdr_base, hdr_idx;
    logic [16:0]                    consumed_q, consumed_d;
    logic [7:0]                     data_id_q, data_id_d, ecc_q, ecc_d;
    logic [15:0]                    word_count_q, word_count_d, crc_q, crc_d;
    logic [LANES-1:0][7:0]          payload_data_q, payload_data_d;
    logic [LANES-1:0]               payload_valid_q, payload_valid_d;
    logic                           header_valid_q, header_valid_d;
    logic                           packet_end_q, packet_end_d;
    logic                           error_q, error_d;
    logic                           beat, skew, hdr_done, go_flush;
    byte_kind_e                     lane_kind [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_kind
        csi2_lane_byte_classifier u_classifier (
            .consumed_i  (consumed_q),
            .word_count_i(word_count_q),
            .lane_i      (3'(l)),
            .kind_o      (lane_kind[l])
        );
    end

    always_comb begin
        beat            = &rx.lane_enable;
        skew            = (|rx.lane_enable) && !beat;
        state_d         = state_q;
        flush_d         = flush_q;
        tmo_d           = tmo_q;
        tmo_next        = tmo_q + 1'b1;
        hdr_d           = hdr_q;
        hdr_cnt_d       = hdr_cnt_q;
        hdr_base        = (state_q == StIdle) ? 3'd0 : hdr_cnt_q;
        hdr_idx         = '0;
        hdr_done        = (hdr_base + LanesHdr) >= 3'(HEADER_BYTES);
        consumed_d      = consumed_q;
        data_id_d       = data_id_q;
        word_count_d    = word_count_q;
        ecc_d           = ecc_q;
        crc_d           = crc_q;
        payload_data_d  = payload_data_q;
        payload_valid_d = '0;
        header_valid_d  = 1'b0;
        packet_end_d    = 1'b0;
        error_d         = 1'b0;
        go_flush        = 1'b0;

        if (state_q == StFlush) begin
            if (flush_q <= FlushW'(1)) state_d = StIdle;
            else flush_d = flush_q - 1'b1;
        end else if (skew) begin
            error_d  = 1'b1;
            go_flush = 1'b1;
        end else if (beat) begin
            tmo_d = '0;
            if (state_q == StPayload) begin
                payload_data_d = rx.lane_data;
                for (int unsigned l = 0; l < LANES; l++) begin
                    case (lane_kind[l])
                        KindPayload: payload_valid_d[l] = 1'b1;
                        KindCrc0:    crc_d[7:0]         = rx.lane_data[l];
                        KindCrc1:    crc_d[15:8]        = rx.lane_data[l];
                        default:     ;
                    endcase
                end
                consumed_d = consumed_q + LanesW;
                if (consumed_q + LanesW >= {1'b0, word_count_q} + 17'(CRC_BYTES)) begin
                    packet_end_d = 1'b1;
                    go_flush     = 1'b1;
                end
            end else begin
                // Bytes beyond the header in its final beat are dropped here.
                for (int unsigned l = 0; l < LANES; l++) begin
                    hdr_idx = hdr_base + 3'(l);
                    if (hdr_idx < 3'(HEADER_BYTES)) hdr_d[hdr_idx[1:0]] = rx.lane_data[l];
                end
                hdr_cnt_d = hdr_base + LanesHdr;
                if (hdr_done) begin
                    header_valid_d = 1'b1;
                    data_id_d      = hdr_d[HDR_DATA_ID];
                    word_count_d   = {hdr_d[HDR_WC_HI], hdr_d[HDR_WC_LO]};
                    ecc_d          = hdr_d[HDR_ECC];
                    crc_d          = '0;
                    consumed_d     = '0;
                    if (hdr_d[HDR_DATA_ID][5:0] < SHORT_PACKET_DT_LIMIT) begin
                        packet_end_d = 1'b1;
                        go_flush     = 1'b1;
                    end else begin
                        state_d = StPayload;
                    end
                end else begin
                    state_d = StHeader;
                end
            end
        end else if (state_q != StIdle) begin
            if (tmo_next == TmoMax) begin
                error_d  = 1'b1;
                go_flush = 1'b1;
            end else begin
                tmo_d = tmo_next;
            end
        end

        if (go_flush) begin
            state_d = StFlush;
            flush_d = FlushW'(FLUSH_CYCLES);
            tmo_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q         <= StFlush;
            flush_q         <= FlushW'(FLUSH_CYCLES);
            tmo_q           <= '0;
            hdr_q           <= '0;
            hdr_cnt_q       <= '0;
            consumed_q      <= '0;
            data_id_q       <= '0;
            word_count_q    <= '0;
            ecc_q           <= '0;
            crc_q           <= '0;
            payload_data_q  <= '0;
            payload_valid_q <= '0;
            header_valid_q  <= 1'b0;
            packet_end_q    <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            flush_q         <= flush_d;
            tmo_q           <= tmo_d;
            hdr_q           <= hdr_d;
            hdr_cnt_q       <= hdr_cnt_d;
            consumed_q      <= consumed_d;
            data_id_q       <= data_id_d;
            word_count_q    <= word_count_d;
            ecc_q           <= ecc_d;
            crc_q           <= crc_d;
            payload_data_q  <= payload_data_d;
            payload_valid_q <= payload_valid_d;
            header_valid_q  <= header_valid_d;
            packet_end_q    <= packet_end_d;
            error_q         <= error_d;
        end
    end

    assign rx.lane_reset    = (state_q == StFlush);
    assign rx.header_valid  = header_valid_q;
    assign rx.data_id       = data_id_q;
    assign rx.word_count    = word_count_q;
    assign rx.ecc           = ecc_q;
    assign rx.payload_data  = payload_data_q;
    assign rx.payload_valid = payload_valid_q;
    assign rx.crc           = crc_q;
    assign rx.packet_end    = packet_end_q;
    assign rx.error         = error_q;

endmodule
